// File: rtl/id_ex_if.sv
// ---------------------------------------------------------------------------
// id_ex_if -- bundle between the decode stage and the ID/EX pipeline latch.
//
// Signals:
//   en, flush           stage enable (0 = hold) and branch/jump squash
//   *_next              decode-stage results presented to the latch
//   nPC .. halt         registered fields presented to the execute stage
//   valid               1 = real instruction held, 0 = bubble
//   lu_stall            combinational load-use stall back to fetch/decode
//   bubble_cnt          bubble counter, present only with ID_EX_PERF_EN
//
// Modports:
//   master  decode / control side (drives *_next, en, flush)
//   slave   the ID/EX latch itself
// ---------------------------------------------------------------------------
interface id_ex_if;
    logic        en;
    logic        flush;

    logic [31:0] nPC_next;
    logic [4:0]  rs_next;
    logic [4:0]  rt_next;
    logic [4:0]  regDst_next;
    logic        dREN_next;
    logic        dWEN_next;
    logic        regWr_next;
    logic [1:0]  regSel_next;
    logic [1:0]  ALUSrc_next;
    logic [3:0]  ALUOp_next;
    logic [31:0] rdat1_next;
    logic [31:0] rdat2_next;
    logic [31:0] imm_next;
    logic [31:0] lui_next;
    logic [4:0]  shamt_next;
    logic        halt_next;

    logic [31:0] nPC;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  regDst;
    logic        dREN;
    logic        dWEN;
    logic        regWr;
    logic [1:0]  regSel;
    logic [1:0]  ALUSrc;
    logic [3:0]  ALUOp;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [31:0] imm;
    logic [31:0] lui;
    logic [4:0]  shamt;
    logic        halt;
    logic        valid;
    logic        lu_stall;
`ifdef ID_EX_PERF_EN
    logic [15:0] bubble_cnt;
`endif

    modport master (
        output en, flush,
        output nPC_next, rs_next, rt_next, regDst_next, dREN_next, dWEN_next,
               regWr_next, regSel_next, ALUSrc_next, ALUOp_next, rdat1_next,
               rdat2_next, imm_next, lui_next, shamt_next, halt_next,
        input  nPC, rs, rt, regDst, dREN, dWEN, regWr, regSel, ALUSrc, ALUOp,
               rdat1, rdat2, imm, lui, shamt, halt, valid, lu_stall
`ifdef ID_EX_PERF_EN
        , input bubble_cnt
`endif
    );

    modport slave (
        input  en, flush,
        input  nPC_next, rs_next, rt_next, regDst_next, dREN_next, dWEN_next,
               regWr_next, regSel_next, ALUSrc_next, ALUOp_next, rdat1_next,
               rdat2_next, imm_next, lui_next, shamt_next, halt_next,
        output nPC, rs, rt, regDst, dREN, dWEN, regWr, regSel, ALUSrc, ALUOp,
               rdat1, rdat2, imm, lui, shamt, halt, valid, lu_stall
`ifdef ID_EX_PERF_EN
        , output bubble_cnt
`endif
    );
endinterface

// File: rtl/id_ex_latch.sv
// ---------------------------------------------------------------------------
// id_ex_latch -- ID/EX pipeline register of the 5-stage CPU.
//
// Captures the decode-stage *_next results on each enabled cycle and
// presents them registered to EX. Detects load-use hazards against the
// instruction currently in EX, loads a single bubble and raises lu_stall
// so that fetch/decode freeze and re-present the dependent instruction.
//
// Ports:
//   CLK       system clock
//   RST       synchronous active-high reset (loads a bubble)
//   bus       id_ex_if.slave: en, flush, *_next in; registered fields,
//             valid, lu_stall (and bubble_cnt) out
//
// Parameters:
//   RESET_NPC value of nPC after reset, flush or bubble
//
// Optional feature macro: ID_EX_PERF_EN -- adds a saturating 16-bit
// bubble_cnt counting bubbles caused by lu_stall or flush.
// ---------------------------------------------------------------------------
module id_ex_latch #(
    parameter logic [31:0] RESET_NPC = 32'h0000_0000
) (
    input  logic CLK,
    input  logic RST,
    id_ex_if.slave bus
);

    typedef struct packed {
        logic [31:0] nPC;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  regDst;
        logic        dREN;
        logic        dWEN;
        logic        regWr;
        logic [1:0]  regSel;
        logic [1:0]  ALUSrc;
        logic [3:0]  ALUOp;
        logic [31:0] rdat1;
        logic [31:0] rdat2;
        logic [31:0] imm;
        logic [31:0] lui;
        logic [4:0]  shamt;
        logic        halt;
    } ex_fields_t;

    // Bubble: every control and data field cleared, nPC parked at RESET_NPC.
    function automatic ex_fields_t bubble_fields();
        ex_fields_t f;
        f     = '0;
        f.nPC = RESET_NPC;
        return f;
    endfunction

    ex_fields_t dec_p0;
    ex_fields_t ex_p1;
    logic       vld_p1;
    logic       lu_stall;

    // ---- stage p0: decode results as presented this cycle ----
    always_comb begin
        dec_p0        = '0;
        dec_p0.nPC    = bus.nPC_next;
        dec_p0.rs     = bus.rs_next;
        dec_p0.rt     = bus.rt_next;
        dec_p0.regDst = bus.regDst_next;
        dec_p0.dREN   = bus.dREN_next;
        dec_p0.dWEN   = bus.dWEN_next;
        dec_p0.regWr  = bus.regWr_next;
        dec_p0.regSel = bus.regSel_next;
        dec_p0.ALUSrc = bus.ALUSrc_next;
        dec_p0.ALUOp  = bus.ALUOp_next;
        dec_p0.rdat1  = bus.rdat1_next;
        dec_p0.rdat2  = bus.rdat2_next;
        dec_p0.imm    = bus.imm_next;
        dec_p0.lui    = bus.lui_next;
        dec_p0.shamt  = bus.shamt_next;
        dec_p0.halt   = bus.halt_next;
    end

    // Hazard: a real load in EX writing a non-$zero register that the
    // instruction in decode reads. A double match still yields one bubble,
    // and once the bubble is in EX valid=0 drops the request.
    always_comb begin
        lu_stall = ex_p1.dREN && vld_p1 && (ex_p1.regDst != 5'd0) &&
                   ((ex_p1.regDst == bus.rs_next) ||
                    (ex_p1.regDst == bus.rt_next));
    end

    // ---- stage p1: ID/EX register ----
    // flush outranks the hold so a squash is never lost to a memory stall.
    always_ff @(posedge CLK) begin
        if (RST || bus.flush) begin
            ex_p1  <= bubble_fields();
            vld_p1 <= 1'b0;
        end else if (!bus.en) begin
            ex_p1  <= ex_p1;
            vld_p1 <= vld_p1;
        end else if (lu_stall) begin
            ex_p1  <= bubble_fields();
            vld_p1 <= 1'b0;
        end else begin
            ex_p1  <= dec_p0;
            vld_p1 <= 1'b1;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [15:0] bubble_cnt_p1;

    // Counts flush bubbles (even while held) and load-use bubbles (only when
    // enabled, since a held cycle loads nothing); RST bubbles are not counted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bubble_cnt_p1 <= 16'd0;
        end else if ((bus.flush || (bus.en && lu_stall)) &&
                     (bubble_cnt_p1 != 16'hFFFF)) begin
            bubble_cnt_p1 <= bubble_cnt_p1 + 16'd1;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_p1;
`endif

    assign bus.nPC      = ex_p1.nPC;
    assign bus.rs       = ex_p1.rs;
    assign bus.rt       = ex_p1.rt;
    assign bus.regDst   = ex_p1.regDst;
    assign bus.dREN     = ex_p1.dREN;
    assign bus.dWEN     = ex_p1.dWEN;
    assign bus.regWr    = ex_p1.regWr;
    assign bus.regSel   = ex_p1.regSel;
    assign bus.ALUSrc   = ex_p1.ALUSrc;
    assign bus.ALUOp    = ex_p1.ALUOp;
    assign bus.rdat1    = ex_p1.rdat1;
    assign bus.rdat2    = ex_p1.rdat2;
    assign bus.imm      = ex_p1.imm;
    assign bus.lui      = ex_p1.lui;
    assign bus.shamt    = ex_p1.shamt;
    assign bus.halt     = ex_p1.halt;
    assign bus.valid    = vld_p1;
    assign bus.lu_stall = lu_stall;

endmodule

// File: tb/tb_id_ex_latch.sv
// ---------------------------------------------------------------------------
// tb_id_ex_latch -- directed bench for id_ex_latch.
// Inputs change #1 after the rising edge; outputs are checked at that point
// (registered outputs) or after the inputs settle (lu_stall).
// ---------------------------------------------------------------------------
module tb_id_ex_latch;

    localparam logic [31:0] RNPC = 32'h0000_0400;

    logic CLK = 1'b0;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    id_ex_if bus ();

    id_ex_latch #(.RESET_NPC(RNPC)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one decoded instruction; secondary fields are derived from
    // rdat1 so that every field carries a distinct value.
    task automatic put(input logic [31:0] npc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic dren, input logic regwr,
                       input logic [31:0] r1, input logic hlt);
        bus.nPC_next    = npc;
        bus.rs_next     = rs;
        bus.rt_next     = rt;
        bus.regDst_next = rd;
        bus.dREN_next   = dren;
        bus.dWEN_next   = 1'b0;
        bus.regWr_next  = regwr;
        bus.regSel_next = dren ? 2'd1 : 2'd2;
        bus.ALUSrc_next = dren ? 2'd1 : 2'd0;
        bus.ALUOp_next  = 4'h3;
        bus.rdat1_next  = r1;
        bus.rdat2_next  = r1 ^ 32'h0000_FF00;
        bus.imm_next    = 32'h0000_1234;
        bus.lui_next    = 32'hABCD_0000;
        bus.shamt_next  = 5'd3;
        bus.halt_next   = hlt;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_npc"},   bus.nPC, RNPC);
        chk({tag, "_valid"}, {31'd0, bus.valid}, 32'd0);
        chk({tag, "_regwr"}, {31'd0, bus.regWr}, 32'd0);
        chk({tag, "_dren"},  {31'd0, bus.dREN}, 32'd0);
        chk({tag, "_halt"},  {31'd0, bus.halt}, 32'd0);
        chk({tag, "_data"},  bus.rdat1 | bus.rdat2 | bus.imm | bus.lui, 32'd0);
        chk({tag, "_sel"},   {11'd0, bus.rs, bus.rt, bus.regDst, bus.ALUOp,
                              bus.regSel, bus.ALUSrc, bus.shamt, bus.dWEN}, 32'd0);
    endtask

    initial begin
        // Reset with random inputs
        RST       = 1'b1;
        bus.en    = 1'b1;
        bus.flush = 1'b0;
        put($urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, $urandom, 1'b1);
        tick();
        tick();
        chk_bubble("reset");
        chk("reset_lu_stall", {31'd0, bus.lu_stall}, 32'd0);
`ifdef ID_EX_PERF_EN
        chk("reset_cnt", {16'd0, bus.bubble_cnt}, 32'd0);
`endif

        // Straight addu
        RST = 1'b0;
        put(32'h0000_0104, 5'd8, 5'd9, 5'd10, 1'b0, 1'b1, 32'h5, 1'b0);
        tick();
        chk("addu_npc",    bus.nPC, 32'h0000_0104);
        chk("addu_regs",   {17'd0, bus.rs, bus.rt, bus.regDst}, {17'd0, 5'd8, 5'd9, 5'd10});
        chk("addu_rdat1",  bus.rdat1, 32'h5);
        chk("addu_rdat2",  bus.rdat2, 32'h0000_FF05);
        chk("addu_imm",    bus.imm, 32'h0000_1234);
        chk("addu_lui",    bus.lui, 32'hABCD_0000);
        chk("addu_ctl",    {19'd0, bus.ALUOp, bus.regSel, bus.ALUSrc, bus.shamt},
                           {19'd0, 4'h3, 2'd2, 2'd0, 5'd3});
        chk("addu_flags",  {27'd0, bus.dREN, bus.dWEN, bus.regWr, bus.halt, bus.valid},
                           {27'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        chk("addu_lu_stall", {31'd0, bus.lu_stall}, 32'd0);

        // Load-use via rs: lw $8, then add reading $8
        put(32'h0000_0108, 5'd29, 5'd8, 5'd8, 1'b1, 1'b1, 32'h1000, 1'b0);
        tick();
        chk("lw_dren",  {31'd0, bus.dREN}, 32'd1);
        chk("lw_valid", {31'd0, bus.valid}, 32'd1);
        put(32'h0000_010C, 5'd8, 5'd11, 5'd12, 1'b0, 1'b1, 32'h77, 1'b0);
        #1;
        chk("lu_rs_stall", {31'd0, bus.lu_stall}, 32'd1);
        tick();
        chk_bubble("lu_bubble");
        chk("lu_after_stall", {31'd0, bus.lu_stall}, 32'd0);
`ifdef ID_EX_PERF_EN
        chk("lu_cnt", {16'd0, bus.bubble_cnt}, 32'd1);
`endif
        tick();
        chk("lu_dep_npc",  bus.nPC, 32'h0000_010C);
        chk("lu_dep_regs", {17'd0, bus.rs, bus.rt, bus.regDst}, {17'd0, 5'd8, 5'd11, 5'd12});
        chk("lu_dep_valid", {31'd0, bus.valid}, 32'd1);

        // Load-use with both rs and rt matching: one bubble only
        put(32'h0000_0110, 5'd29, 5'd5, 5'd5, 1'b1, 1'b1, 32'h2000, 1'b0);
        tick();
        put(32'h0000_0114, 5'd5, 5'd5, 5'd6, 1'b0, 1'b1, 32'h88, 1'b0);
        #1;
        chk("both_stall", {31'd0, bus.lu_stall}, 32'd1);
        tick();
        chk("both_bubble_valid", {31'd0, bus.valid}, 32'd0);
        chk("both_after_stall", {31'd0, bus.lu_stall}, 32'd0);
        tick();
        chk("both_dep_npc", bus.nPC, 32'h0000_0114);
        chk("both_dep_valid", {31'd0, bus.valid}, 32'd1);
`ifdef ID_EX_PERF_EN
        chk("both_cnt", {16'd0, bus.bubble_cnt}, 32'd2);
`endif

        // Load to $zero never stalls
        put(32'h0000_0118, 5'd29, 5'd0, 5'd0, 1'b1, 1'b1, 32'h3000, 1'b0);
        tick();
        put(32'h0000_011C, 5'd0, 5'd0, 5'd13, 1'b0, 1'b1, 32'h99, 1'b0);
        #1;
        chk("zero_stall", {31'd0, bus.lu_stall}, 32'd0);
        tick();
        chk("zero_npc", bus.nPC, 32'h0000_011C);
        chk("zero_valid", {31'd0, bus.valid}, 32'd1);

        // Hold: latch lw $7 (halt set), then en=0 for 3 cycles with a consumer
        put(32'h0000_0120, 5'd29, 5'd7, 5'd7, 1'b1, 1'b1, 32'h4444, 1'b1);
        tick();
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(32'h0000_0200 + 32'(i), 5'd7, 5'd1, 5'd2, 1'b0, 1'b1, 32'hDEAD_0000 + 32'(i), 1'b0);
            #1;
            chk("hold_stall", {31'd0, bus.lu_stall}, 32'd1);
            tick();
            chk("hold_npc",   bus.nPC, 32'h0000_0120);
            chk("hold_rdat1", bus.rdat1, 32'h4444);
            chk("hold_flags", {28'd0, bus.dREN, bus.regWr, bus.halt, bus.valid}, 32'h0000_000F);
        end
`ifdef ID_EX_PERF_EN
        chk("hold_cnt", {16'd0, bus.bubble_cnt}, 32'd2);
`endif

        // Flush while held: squash wins over en=0 and clears halt
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk_bubble("flush");
`ifdef ID_EX_PERF_EN
        chk("flush_cnt", {16'd0, bus.bubble_cnt}, 32'd3);
`endif

        // RST mid-stall with en=0 overrides the hold
        bus.en = 1'b1;
        put(32'h0000_0130, 5'd29, 5'd4, 5'd4, 1'b1, 1'b1, 32'h5555, 1'b0);
        tick();
        bus.en = 1'b0;
        put(32'h0000_0134, 5'd4, 5'd3, 5'd2, 1'b0, 1'b1, 32'h66, 1'b0);
        #1;
        chk("rst_pre_stall", {31'd0, bus.lu_stall}, 32'd1);
        RST = 1'b1;
        tick();
        chk_bubble("rst_mid");
`ifdef ID_EX_PERF_EN
        chk("rst_cnt", {16'd0, bus.bubble_cnt}, 32'd0);
`endif
        RST    = 1'b0;
        bus.en = 1'b1;
        tick();
        chk("post_rst_npc",   bus.nPC, 32'h0000_0134);
        chk("post_rst_valid", {31'd0, bus.valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- ID/EX pipeline register of the 5-stage pipelined CPU; the consumer of every decode-stage `*_next` output.
- Captures decode results on each enabled cycle and presents them registered to the execute stage.
- Detects load-use hazards against the instruction currently in EX, inserts bubbles, and drives the stall request back to fetch/decode.

Parameters:
- RESET_NPC, 32'h0000_0000, value loaded into nPC on reset, flush and bubble.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- en  in  1  stage enable from the memory-stall controller; 0 holds all registers.
- flush  in  1  branch/jump squash; next edge loads a bubble.
- nPC_next -> nPC  in -> out  32  pass-through next-PC.
- rs_next -> rs, rt_next -> rt  in -> out  5 each  source register numbers.
- regDst_next -> regDst  in -> out  5  destination register (Wsel).
- dREN_next -> dREN, dWEN_next -> dWEN, regWr_next -> regWr  in -> out  1 each  control bits.
- regSel_next -> regSel, ALUSrc_next -> ALUSrc  in -> out  2 each  writeback mux and ALU B-operand select.
- ALUOp_next -> ALUOp  in -> out  4  aluop_t.
- rdat1_next -> rdat1, rdat2_next -> rdat2, imm_next -> imm, lui_next -> lui  in -> out  32 each  operands.
- shamt_next -> shamt  in -> out  5  shift amount ([SHAM_W:0]).
- halt_next -> halt  in -> out  1  halt marker.
- valid  out  1  1 = real instruction held, 0 = bubble.
- lu_stall  out  1  combinational load-use stall request to fetch and decode.

Behaviour:
- Bubble value: every control output 0 (dREN, dWEN, regWr, halt, valid); all data/select fields 0; ALUOp = 0; nPC = RESET_NPC.
- lu_stall = dREN & valid & (regDst != 0) & ((regDst == rs_next) | (regDst == rt_next)). Purely from current registers plus decode inputs; no added latency.
- Update priority at each rising CLK edge, highest first:
  1. RST → bubble.
  2. flush → bubble. Applies even when en = 0; a squash is never lost to a stall.
  3. en = 0 → hold all registers unchanged. lu_stall keeps reflecting held contents.
  4. lu_stall → bubble. Decode is frozen by lu_stall, so the stalled instruction is re-presented next cycle.
  5. Otherwise load all `*_next` inputs; valid = 1.
- Latency: exactly one cycle from `*_next` to output. No combinational path from inputs to any output except lu_stall.
- Single-cycle hazard: after one bubble, the load leaves EX, valid = 0, and lu_stall deasserts. This guarantees exactly one bubble per load-use pair.
- regDst = 0 never raises lu_stall ($zero writes are ignored).
- A load whose rs and rt both match counts as one hazard and produces one bubble.
- halt is not sticky here; it propagates like any other field and is cleared by flush.
- RST asserted mid-stall overrides everything, including en = 0; the first cycle after RST deasserts behaves as a normal enabled cycle.

Optional Feature:
- ID_EX_PERF_EN defined:
  - Adds output `bubble_cnt [15:0]`, reset to 0 by RST.
  - Increments on every edge where a bubble is loaded because of lu_stall or flush (not RST); saturates at 16'hFFFF.
  - Hold cycles (en = 0) do not count.
- ID_EX_PERF_EN undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: RST = 1 for 2 cycles with random inputs → all outputs 0, nPC = RESET_NPC, valid = 0, lu_stall = 0.
- Straight load: en = 1, addu with rs = 8, rt = 9, regDst = 10, rdat1 = 32'h5 → next cycle outputs match inputs, valid = 1, lu_stall = 0.
- Load-use: lw regDst = 8 latched (dREN = 1), then decode presents rs_next = 8 → lu_stall = 1 same cycle; next edge gives bubble (regWr = 0, valid = 0), lu_stall = 0; following edge latches the dependent instruction.
- $zero load: lw regDst = 0 followed by rs_next = 0 → lu_stall stays 0, no bubble.
- Flush during stall: en = 0 holding an add, flush = 1 → next edge gives bubble. With ID_EX_PERF_EN, bubble_cnt goes 0 → 1.
- Hold: en = 0 for 3 cycles while inputs change → outputs unchanged. With ID_EX_PERF_EN, bubble_cnt is not incremented.
